// File: rtl/countdown_arbiter_ctrl_if.sv
// Request/response bus between requesters and the countdown arbiter controller.
// Packed per-requester fields: [W-1:0] is requester 0, [2W-1:W] is requester 1.
interface countdown_arbiter_ctrl_if #(
   parameter int W  = 8,
   parameter int CW = 8
);
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_start;
   logic [2*W-1:0] req_step;
   logic [1:0]     rsp_valid;
   logic           rsp_err;
   logic [CW-1:0]  rsp_iters;

   modport master (
      output req_valid, req_start, req_step,
      input  req_ready, rsp_valid, rsp_err, rsp_iters
   );

   modport slave (
      input  req_valid, req_start, req_step,
      output req_ready, rsp_valid, rsp_err, rsp_iters
   );
endinterface

// File: rtl/countdown_arbiter_ctrl.sv
// Round-robin sequencer sharing one X/Y countdown datapath between two requesters;
// returns the subtraction count and an error flag to the owner of each job.
module countdown_arbiter_ctrl #(
   parameter int W         = 8,
   parameter int CW        = 8,
   parameter int MAX_ITERS = 200
) (
   input  logic                     clk,
   input  logic                     reset_n,
   countdown_arbiter_ctrl_if.slave  bus,
   output logic                     busy,
   output logic [1:0]               dp_op_sel,
   output logic                     dp_en_x,
   output logic                     dp_en_y,
   output logic                     dp_y_sel,
   output logic [W-1:0]             dp_y_data,
   input  logic                     dp_zero
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LOAD_START = 3'd1;
   localparam logic [2:0] S_COPY_X     = 3'd2;
   localparam logic [2:0] S_LOAD_STEP  = 3'd3;
   localparam logic [2:0] S_RUN        = 3'd4;
   localparam logic [2:0] S_RESP       = 3'd5;

   localparam logic [1:0] OP_SUB  = 2'd2;
   localparam logic [1:0] OP_COPY = 2'd3;

   localparam logic [CW-1:0] ITER_LIMIT = CW'(MAX_ITERS);

   logic [2:0]    state;
   logic          rr_ptr;
   logic          owner;
   logic          err_q;
   logic [W-1:0]  start_q;
   logic [W-1:0]  step_q;
   logic [CW-1:0] iters;

   logic          grant_vld;
   logic          grant_idx;
   logic [W-1:0]  grant_start;
   logic [W-1:0]  grant_step;

   // Grant favours rr_ptr, falling back to the other requester; only offered in IDLE.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_ptr;
      if (state == S_IDLE) begin
         if (bus.req_valid[rr_ptr]) begin
            grant_vld = 1'b1;
            grant_idx = rr_ptr;
         end else if (bus.req_valid[~rr_ptr]) begin
            grant_vld = 1'b1;
            grant_idx = ~rr_ptr;
         end
      end
   end

   assign grant_start = grant_idx ? bus.req_start[2*W-1:W] : bus.req_start[W-1:0];
   assign grant_step  = grant_idx ? bus.req_step[2*W-1:W]  : bus.req_step[W-1:0];

   assign bus.req_ready = grant_vld ? (2'b01 << grant_idx) : 2'b00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         rr_ptr  <= 1'b0;
         owner   <= 1'b0;
         err_q   <= 1'b0;
         start_q <= '0;
         step_q  <= '0;
         iters   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  owner   <= grant_idx;
                  start_q <= grant_start;
                  step_q  <= grant_step;
                  iters   <= '0;
                  if (grant_step == '0) begin
                     err_q <= 1'b1;
                     state <= S_RESP;
                  end else begin
                     err_q <= 1'b0;
                     state <= S_LOAD_START;
                  end
               end
            end
            S_LOAD_START: state <= S_COPY_X;
            S_COPY_X:     state <= S_LOAD_STEP;
            S_LOAD_STEP:  state <= S_RUN;
            S_RUN: begin
               // Zero wins over the limit so a job landing exactly on MAX_ITERS succeeds.
               if (dp_zero) begin
                  err_q <= 1'b0;
                  state <= S_RESP;
               end else if (iters == ITER_LIMIT) begin
                  err_q <= 1'b1;
                  state <= S_RESP;
               end else begin
                  iters <= iters + CW'(1);
               end
            end
            S_RESP: begin
               rr_ptr <= ~owner;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy          = (state != S_IDLE);
      dp_op_sel     = 2'b00;
      dp_en_x       = 1'b0;
      dp_en_y       = 1'b0;
      dp_y_sel      = 1'b0;
      dp_y_data     = '0;
      bus.rsp_valid = 2'b00;
      bus.rsp_err   = 1'b0;
      bus.rsp_iters = '0;
      case (state)
         S_LOAD_START: begin
            dp_y_sel  = 1'b1;
            dp_en_y   = 1'b1;
            dp_y_data = start_q;
         end
         S_COPY_X: begin
            dp_op_sel = OP_COPY;
            dp_en_x   = 1'b1;
         end
         S_LOAD_STEP: begin
            dp_y_sel  = 1'b1;
            dp_en_y   = 1'b1;
            dp_y_data = step_q;
         end
         S_RUN: begin
            if (!dp_zero && iters != ITER_LIMIT) begin
               dp_op_sel = OP_SUB;
               dp_en_x   = 1'b1;
            end
         end
         S_RESP: begin
            bus.rsp_valid = 2'b01 << owner;
            bus.rsp_err   = err_q;
            bus.rsp_iters = iters;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_countdown_arbiter_ctrl.sv
// Bench for countdown_arbiter_ctrl: behavioural X/Y datapath, vector table of jobs,
// response scoreboard, plus arbitration and mid-job reset sequences.
module tb_countdown_arbiter_ctrl;

   localparam int W  = 8;
   localparam int CW = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         busy;
   logic [1:0]   dp_op_sel;
   logic         dp_en_x, dp_en_y, dp_y_sel;
   logic [W-1:0] dp_y_data;
   logic         dp_zero;

   logic [W-1:0] x_r = '0;
   logic [W-1:0] y_r = '0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int nx    = 0;
   int ny    = 0;

   typedef struct {
      int owner;
      int err;
      int iters;
      int due;
      int nx;
      int ny;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      int           idx;
      logic [W-1:0] start;
      logic [W-1:0] step;
      int           err;
      int           iters;
      int           lat;
   } vec_t;

   countdown_arbiter_ctrl_if #(.W(W), .CW(CW)) bus ();

   countdown_arbiter_ctrl #(.W(W), .CW(CW), .MAX_ITERS(200)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .busy      (busy),
      .dp_op_sel (dp_op_sel),
      .dp_en_x   (dp_en_x),
      .dp_en_y   (dp_en_y),
      .dp_y_sel  (dp_y_sel),
      .dp_y_data (dp_y_data),
      .dp_zero   (dp_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Datapath: X/Y registers with copy and wrapping subtract.
   always @(posedge clk) begin
      if (dp_en_y && dp_y_sel) y_r <= dp_y_data;
      if (dp_en_x) begin
         if (dp_op_sel == 2'd3) x_r <= y_r;
         else if (dp_op_sel == 2'd2) x_r <= x_r - y_r;
      end
   end
   assign dp_zero = (x_r == '0);

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Response monitor and scoreboard.
   always @(negedge clk) begin
      if (!reset_n) begin
         nx = 0;
         ny = 0;
      end else begin
         if (dp_en_x) nx++;
         if (dp_en_y) ny++;
         if (!dp_en_x) chk("op_sel_idle", int'(dp_op_sel), 0);
         if (!dp_en_y) chk("y_data_idle", int'(dp_y_data), 0);
         if (bus.rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", int'(bus.rsp_valid), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_owner", int'(bus.rsp_valid), 1 << e.owner);
               chk("rsp_err", int'(bus.rsp_err), e.err);
               chk("rsp_iters", int'(bus.rsp_iters), e.iters);
               chk("rsp_cycle", cyc, e.due);
               chk("resp_en_x", int'(dp_en_x), 0);
               chk("resp_busy", int'(busy), 1);
               chk("en_x_count", nx, e.nx);
               chk("en_y_count", ny, e.ny);
            end
            nx = 0;
            ny = 0;
         end
      end
   end

   task automatic push_exp(input int owner, input logic [W-1:0] step,
                           input int err, input int iters, input int lat);
      exp_t e;
      e.owner = owner;
      e.err   = err;
      e.iters = iters;
      e.due   = cyc + lat;
      e.nx    = (step == '0) ? 0 : iters + 1;
      e.ny    = (step == '0) ? 0 : 2;
      sb.push_back(e);
   endtask

   task automatic set_req(input int idx, input logic [W-1:0] start, input logic [W-1:0] step);
      bus.req_valid[idx] = 1'b1;
      bus.req_start[idx*W +: W] = start;
      bus.req_step[idx*W +: W]  = step;
   endtask

   task automatic drop_reqs();
      bus.req_valid = 2'b00;
      bus.req_start = 16'($urandom);
      bus.req_step  = 16'($urandom);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("rsp_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic run_job(input vec_t v);
      @(negedge clk);
      bus.req_valid = 2'b00;
      set_req(v.idx, v.start, v.step);
      #1;
      chk("grant", int'(bus.req_ready), 1 << v.idx);
      push_exp(v.idx, v.step, v.err, v.iters, v.lat);
      @(posedge clk);
      #1;
      drop_reqs();
      wait_done();
   endtask

   task automatic check_all_zero(input string nm);
      logic [31:0] o;
      o = {5'd0, busy, dp_op_sel, dp_en_x, dp_en_y, dp_y_sel, dp_y_data,
           bus.rsp_valid, bus.rsp_err, bus.rsp_iters, bus.req_ready};
      chk(nm, int'(o), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[8];
      // RESP comes one cycle after the RUN cycle that observes X==0.
      vecs[0] = '{0,   8'd6,   8'd2, 0,   3,   8};
      vecs[1] = '{1,   8'd0,   8'd5, 0,   0,   5};
      vecs[2] = '{0,   8'd9,   8'd0, 1,   0,   1};
      vecs[3] = '{1,   8'd7,   8'd2, 1, 200, 205};
      vecs[4] = '{0, 8'd200,   8'd1, 0, 200, 205};
      vecs[5] = '{1, 8'd201,   8'd1, 1, 200, 205};
      vecs[6] = '{0, 8'd250,  8'd50, 0,   5,  10};
      vecs[7] = '{1, 8'd255, 8'd255, 0,   1,   6};

      bus.req_valid = 2'b00;
      bus.req_start = '0;
      bus.req_step  = '0;
      #12;
      check_all_zero("reset_outputs");
      @(negedge clk);
      reset_n = 1'b1;

      // Simultaneous requests: req0 first, then req1 despite req0 re-requesting.
      @(negedge clk);
      set_req(0, 8'd4, 8'd2);
      set_req(1, 8'd6, 8'd3);
      #1;
      chk("arb_first", int'(bus.req_ready), 1);
      push_exp(0, 8'd2, 0, 2, 7);
      @(posedge clk);
      #1;
      for (int i = 0; i < 50 && bus.req_ready == 2'b00; i++) @(negedge clk);
      chk("arb_second", int'(bus.req_ready), 2);
      push_exp(1, 8'd3, 0, 2, 7);
      @(posedge clk);
      #1;
      drop_reqs();
      wait_done();

      foreach (vecs[i]) run_job(vecs[i]);

      // Leave rr_ptr at 1, then reset in the middle of a req1 job.
      run_job('{0, 8'd3, 8'd1, 0, 3, 8});
      @(negedge clk);
      set_req(1, 8'd100, 8'd1);
      #1;
      chk("pre_reset_grant", int'(bus.req_ready), 2);
      @(posedge clk);
      #1;
      drop_reqs();
      repeat (20) @(negedge clk);
      chk("pre_reset_busy", int'(busy), 1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset_outputs");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", int'(busy), 0);
      set_req(0, 8'd10, 8'd5);
      set_req(1, 8'd12, 8'd4);
      #1;
      chk("post_reset_grant", int'(bus.req_ready), 1);
      push_exp(0, 8'd5, 0, 2, 7);
      @(posedge clk);
      #1;
      drop_reqs();
      wait_done();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
